// File: rtl/spi_txn_scheduler_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
package spi_txn_scheduler_pkg;

    localparam int unsigned SLAVE_W = 2;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned RW_W    = 2;
    localparam int unsigned DATA_W  = 8;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_XFER    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // SPI modes as {CPOL,CPHA}
    localparam logic [MODE_W-1:0] MODE0 = 2'b00;
    localparam logic [MODE_W-1:0] MODE1 = 2'b01;
    localparam logic [MODE_W-1:0] MODE2 = 2'b10;
    localparam logic [MODE_W-1:0] MODE3 = 2'b11;

    // Read/write enables as {master write, master read}
    localparam logic [RW_W-1:0] RW_NONE  = 2'b00;
    localparam logic [RW_W-1:0] RW_READ  = 2'b01;
    localparam logic [RW_W-1:0] RW_WRITE = 2'b10;
    localparam logic [RW_W-1:0] RW_BOTH  = 2'b11;

    localparam logic [SLAVE_W-1:0] MAX_SLAVE = 2'd2;

    // Configuration of one SPI transfer as driven onto the SPI system
    typedef struct packed {
        logic [SLAVE_W-1:0] slave;
        logic [MODE_W-1:0]  mode;
        logic [RW_W-1:0]    rw;
        logic [DATA_W-1:0]  wdata;
    } spi_cfg_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    // Cyclic search starting at i_ptr, first hit wins
    always_comb begin
        int unsigned w_pos;
        logic        w_found;
        o_grant_c = '0;
        o_idx_c   = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_pos = 32'(i_ptr) + i;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
                w_found                       = 1'b1;
                o_grant_c[w_pos[IDX_W-1:0]] = 1'b1;
                o_idx_c                       = w_pos[IDX_W-1:0];
            end
        end
        o_any_c = w_found;
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Shares the SPI system between requesters and sequences setup/transfer/capture/response.
module spi_txn_scheduler
    import spi_txn_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned XFER_CYCLES  = 80
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_slave,
    input  logic [2*NUM_REQ-1:0]       req_mode,
    input  logic [2*NUM_REQ-1:0]       req_rw,
    input  logic [8*NUM_REQ-1:0]       req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [7:0]                 rsp_rdata,
    output logic                       rsp_err,
    output logic                       spi_enable,
    output logic [1:0]                 spi_mode_select,
    output logic [1:0]                 spi_slave_select,
    output logic [1:0]                 spi_read_write_enable,
    output logic [7:0]                 spi_m2s_data,
    input  logic [7:0]                 spi_master_rdata
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(max_u(SETUP_CYCLES, XFER_CYCLES) + 1);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]  r_req_ready;
    spi_cfg_t            r_cfg;
    logic                r_rsp_valid;
    logic [IDX_W-1:0]    r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_spi_enable;

    state_e              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_rr_ptr_nxt;
    logic [NUM_REQ-1:0]  w_req_ready_nxt;
    spi_cfg_t            w_cfg_nxt;
    logic                w_rsp_valid_nxt;
    logic [IDX_W-1:0]    w_rsp_id_nxt;
    logic [DATA_W-1:0]   w_rsp_rdata_nxt;
    logic                w_rsp_err_nxt;
    logic                w_spi_enable_nxt;

    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_grant_any;
    spi_cfg_t            w_sel_cfg;
    logic                w_legal;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_grant_c (w_grant),
        .o_idx_c   (w_grant_idx),
        .o_any_c   (w_grant_any)
    );

    // Pick the granted requester's configuration fields
    always_comb begin
        w_sel_cfg = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_cfg.slave = req_slave[2*i +: 2];
                w_sel_cfg.mode  = req_mode[2*i +: 2];
                w_sel_cfg.rw    = req_rw[2*i +: 2];
                w_sel_cfg.wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // Legality is judged on the latched copy so no input reaches the FSM decision directly
    assign w_legal = (r_cfg.slave <= MAX_SLAVE) && (r_cfg.rw != RW_NONE);

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_req_ready_nxt  = '0;
        w_cfg_nxt        = r_cfg;
        w_rsp_id_nxt     = r_rsp_id;
        w_rsp_rdata_nxt  = r_rsp_rdata;
        w_rsp_err_nxt    = r_rsp_err;
        w_rsp_valid_nxt  = 1'b0;
        w_spi_enable_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_req_ready != '0) begin
                    // Acceptance cycle: grant is visible, configuration already latched
                    if (w_legal) begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
                    end else begin
                        w_state_nxt     = ST_RESP;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end else if (w_grant_any) begin
                    w_req_ready_nxt = w_grant;
                    w_cfg_nxt       = w_sel_cfg;
                    w_rsp_id_nxt    = w_grant_idx;
                    if (w_grant_idx == IDX_W'(NUM_REQ - 1)) begin
                        w_rr_ptr_nxt = '0;
                    end else begin
                        w_rr_ptr_nxt = w_grant_idx + IDX_W'(1);
                    end
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_XFER;
                    w_cnt_nxt   = CNT_W'(XFER_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_XFER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                w_rsp_rdata_nxt = spi_master_rdata;
                w_rsp_err_nxt   = 1'b0;
                w_state_nxt     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Registered strobes track the state being entered
        w_spi_enable_nxt = (w_state_nxt == ST_XFER);
        w_rsp_valid_nxt  = (w_state_nxt == ST_RESP);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_req_ready  <= '0;
            r_cfg        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_spi_enable <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_cfg        <= w_cfg_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_id     <= w_rsp_id_nxt;
            r_rsp_rdata  <= w_rsp_rdata_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_spi_enable <= w_spi_enable_nxt;
        end
    end

    assign req_ready             = r_req_ready;
    assign rsp_valid             = r_rsp_valid;
    assign rsp_id                = r_rsp_id;
    assign rsp_rdata             = r_rsp_rdata;
    assign rsp_err               = r_rsp_err;
    assign spi_enable            = r_spi_enable;
    assign spi_mode_select       = r_cfg.mode;
    assign spi_slave_select      = r_cfg.slave;
    assign spi_read_write_enable = r_cfg.rw;
    assign spi_m2s_data          = r_cfg.wdata;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed self-checking bench for spi_txn_scheduler.
module tb_spi_txn_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [5:0] req_slave;
    logic [5:0] req_mode;
    logic [5:0] req_rw;
    logic [23:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       spi_enable;
    logic [1:0] spi_mode_select;
    logic [1:0] spi_slave_select;
    logic [1:0] spi_read_write_enable;
    logic [7:0] spi_m2s_data;
    logic [7:0] spi_master_rdata;

    int n_pass  = 0;
    int n_total = 0;

    spi_txn_scheduler #(
        .NUM_REQ      (3),
        .SETUP_CYCLES (2),
        .XFER_CYCLES  (80)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_slave             (req_slave),
        .req_mode              (req_mode),
        .req_rw                (req_rw),
        .req_wdata             (req_wdata),
        .rsp_valid             (rsp_valid),
        .rsp_ready             (rsp_ready),
        .rsp_id                (rsp_id),
        .rsp_rdata             (rsp_rdata),
        .rsp_err               (rsp_err),
        .spi_enable            (spi_enable),
        .spi_mode_select       (spi_mode_select),
        .spi_slave_select      (spi_slave_select),
        .spi_read_write_enable (spi_read_write_enable),
        .spi_m2s_data          (spi_m2s_data),
        .spi_master_rdata      (spi_master_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] slv, input logic [1:0] md,
                           input logic [1:0] rw, input logic [7:0] wd);
        req_slave[2*i +: 2] = slv;
        req_mode[2*i +: 2]  = md;
        req_rw[2*i +: 2]    = rw;
        req_wdata[8*i +: 8] = wd;
    endtask

    task automatic wait_ready(input int max_cyc, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc && !ok) begin
            tick();
            cyc++;
            if (req_ready != 3'b000) ok = 1'b1;
        end
    endtask

    task automatic wait_rsp(input int max_cyc, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc && !ok) begin
            tick();
            cyc++;
            if (rsp_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_en(input int max_cyc, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc && !ok) begin
            tick();
            cyc++;
            if (spi_enable) ok = 1'b1;
        end
    endtask

    initial begin
        int         c;
        logic       ok;
        int         en_cnt;
        int         first_en;
        int         last_en;
        logic       mode_bad;
        logic       hold_bad;
        int         ord [4];
        logic [2:0] exp_rdy;

        rst              = 1'b1;
        req_valid        = '0;
        req_slave        = '0;
        req_mode         = '0;
        req_rw           = '0;
        req_wdata        = '0;
        rsp_ready        = 1'b1;
        spi_master_rdata = '0;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_spi_enable", 32'(spi_enable), 32'h0);
        chk("rst_spi_cfg", 32'({spi_mode_select, spi_slave_select, spi_read_write_enable, spi_m2s_data}), 32'h0);
        rst = 1'b0;

        // Single transaction from requester 0
        set_req(0, 2'd1, 2'b10, 2'b11, 8'hA5);
        spi_master_rdata = 8'h3C;
        req_valid = 3'b001;
        wait_ready(10, c, ok);
        chk("t1_grant_seen", 32'(ok), 32'h1);
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        req_valid = 3'b000;
        en_cnt = 0; first_en = -1; last_en = -1; mode_bad = 1'b0;
        for (int k = 1; k <= 84; k++) begin
            tick();
            if (spi_enable) begin
                en_cnt++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (spi_mode_select != 2'b10) mode_bad = 1'b1;
            if (k == 83) chk("t1_no_early_rsp", 32'(rsp_valid), 32'h0);
        end
        chk("t1_en_count", 32'(en_cnt), 32'd80);
        chk("t1_en_first", 32'(first_en), 32'd3);
        chk("t1_en_last", 32'(last_en), 32'd82);
        chk("t1_mode_stable", 32'(mode_bad), 32'h0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_rdata", 32'(rsp_rdata), 32'h3C);
        chk("t1_rsp_id", 32'(rsp_id), 32'h0);
        chk("t1_rsp_err", 32'(rsp_err), 32'h0);
        chk("t1_slave_rw_data", 32'({spi_slave_select, spi_read_write_enable, spi_m2s_data}), 32'h7A5);
        tick();
        chk("t1_rsp_done", 32'(rsp_valid), 32'h0);

        // Round robin with all three requesters valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 2'd0, 2'b00, 2'b01, 8'h10);
        set_req(1, 2'd1, 2'b01, 2'b10, 8'h11);
        set_req(2, 2'd2, 2'b10, 2'b11, 8'h12);
        req_valid = 3'b111;
        ord = '{0, 1, 2, 0};
        for (int n = 0; n < 4; n++) begin
            wait_ready(200, c, ok);
            chk("rr_grant_seen", 32'(ok), 32'h1);
            exp_rdy = 3'(1 << ord[n]);
            chk("rr_order", 32'(req_ready), 32'(exp_rdy));
            chk("rr_m2s_data", 32'(spi_m2s_data), 32'(8'h10 + 8'(ord[n])));
            if (n > 0) chk("rr_spacing", 32'(c), 32'd86);
        end
        req_valid = 3'b000;
        wait_rsp(200, c, ok);
        chk("rr_last_rsp_seen", 32'(ok), 32'h1);
        chk("rr_last_rsp_id", 32'(rsp_id), 32'h0);
        tick();

        // Illegal request: slave 3 from requester 2
        set_req(2, 2'd3, 2'b00, 2'b11, 8'h77);
        req_valid = 3'b100;
        wait_ready(10, c, ok);
        chk("ill_req_ready", 32'(req_ready), 32'h4);
        req_valid = 3'b000;
        tick();
        chk("ill_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ill_rsp_err", 32'(rsp_err), 32'h1);
        chk("ill_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("ill_rsp_id", 32'(rsp_id), 32'h2);
        chk("ill_no_enable", 32'(spi_enable), 32'h0);
        tick();
        chk("ill_rsp_done", 32'(rsp_valid), 32'h0);
        chk("ill_no_enable_after", 32'(spi_enable), 32'h0);

        // Response backpressure with another requester waiting
        rsp_ready = 1'b0;
        set_req(0, 2'd2, 2'b01, 2'b01, 8'h5C);
        spi_master_rdata = 8'h5A;
        req_valid = 3'b001;
        wait_ready(10, c, ok);
        chk("bp_req_ready", 32'(req_ready), 32'h1);
        set_req(1, 2'd1, 2'b01, 2'b10, 8'h22);
        req_valid = 3'b010;
        wait_rsp(200, c, ok);
        chk("bp_rsp_seen", 32'(ok), 32'h1);
        chk("bp_rsp_rdata", 32'(rsp_rdata), 32'h5A);
        spi_master_rdata = 8'hFF;
        hold_bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!rsp_valid || rsp_rdata != 8'h5A || req_ready != 3'b000) hold_bad = 1'b1;
        end
        chk("bp_hold_stable", 32'(hold_bad), 32'h0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_after_ready", 32'(rsp_valid), 32'h0);
        tick();
        chk("bp_next_grant", 32'(req_ready), 32'h2);

        // Requester 1 changes its mode during its own transfer
        chk("mc_mode_initial", 32'(spi_mode_select), 32'h1);
        wait_en(20, c, ok);
        chk("mc_enable_seen", 32'(ok), 32'h1);
        repeat (10) tick();
        req_mode[3:2] = 2'b11;
        mode_bad = 1'b0;
        c = 0;
        ok = 1'b0;
        while (c < 200 && !ok) begin
            tick();
            c++;
            if (req_ready != 3'b000) ok = 1'b1;
            else if (spi_mode_select != 2'b01) mode_bad = 1'b1;
        end
        chk("mc_regrant_seen", 32'(ok), 32'h1);
        chk("mc_mode_held", 32'(mode_bad), 32'h0);
        chk("mc_regrant_id", 32'(req_ready), 32'h2);
        chk("mc_mode_new", 32'(spi_mode_select), 32'h3);
        req_valid = 3'b000;
        wait_rsp(200, c, ok);
        chk("mc_rsp_rdata", 32'(rsp_rdata), 32'hFF);
        tick();

        // Reset in the middle of a transfer
        req_valid = 3'b001;
        wait_ready(10, c, ok);
        chk("mr_req_ready", 32'(req_ready), 32'h1);
        req_valid = 3'b011;
        wait_en(20, c, ok);
        chk("mr_enable_seen", 32'(ok), 32'h1);
        repeat (39) tick();
        chk("mr_in_xfer", 32'(spi_enable), 32'h1);
        rst = 1'b1;
        tick();
        chk("mr_enable_low", 32'(spi_enable), 32'h0);
        chk("mr_rsp_valid_low", 32'(rsp_valid), 32'h0);
        chk("mr_cfg_cleared", 32'({spi_mode_select, spi_m2s_data}), 32'h0);
        rst = 1'b0;
        tick();
        chk("mr_ptr_reset_grant", 32'(req_ready), 32'h1);
        req_valid = 3'b000;
        wait_rsp(200, c, ok);
        chk("mr_rsp_seen", 32'(ok), 32'h1);
        chk("mr_rsp_id", 32'(rsp_id), 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
